// File: rtl/btb_assoc_if.sv
// Fetch/update/flush bundle for the set-associative BTB.
// The frontend drives it as master; the BTB connects as slave.
interface btb_assoc_if #(
  parameter int unsigned VLEN        = 64,
  parameter int unsigned FETCH_SLOTS = 2
);
  logic                         flush_i;
  logic                         debug_mode_i;
  logic [VLEN-1:0]              vpc_i;
  logic                         update_valid_i;
  logic                         update_clear_i;
  logic [VLEN-1:0]              update_pc_i;
  logic [VLEN-1:0]              update_target_i;
  logic [FETCH_SLOTS-1:0]       pred_valid_o;
  logic [FETCH_SLOTS*VLEN-1:0]  pred_target_o;
  logic                         flush_busy_o;

  modport master (
    output flush_i, debug_mode_i, vpc_i, update_valid_i, update_clear_i,
           update_pc_i, update_target_i,
    input  pred_valid_o, pred_target_o, flush_busy_o
  );

  modport slave (
    input  flush_i, debug_mode_i, vpc_i, update_valid_i, update_clear_i,
           update_pc_i, update_target_i,
    output pred_valid_o, pred_target_o, flush_busy_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with partial tags, round-robin
// replacement, entry clear and a row-sequenced multi-cycle flush.
module btb_assoc #(
  parameter int unsigned NR_ENTRIES  = 32,
  parameter int unsigned NR_WAYS     = 2,
  parameter int unsigned FETCH_SLOTS = 2,
  parameter int unsigned TAG_BITS    = 8,
  parameter int unsigned VLEN        = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  btb_assoc_if.slave   bus
);
  localparam int unsigned NR_ROWS = NR_ENTRIES / (NR_WAYS * FETCH_SLOTS);
  localparam int unsigned SB      = $clog2(FETCH_SLOTS);
  localparam int unsigned ROW_W   = $clog2(NR_ROWS);
  localparam int unsigned ROW_IW  = (ROW_W > 0) ? ROW_W : 1;
  localparam int unsigned SLOT_IW = (SB > 0) ? SB : 1;
  localparam int unsigned PTR_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  function automatic logic [ROW_IW-1:0] row_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] sh;
    sh = pc >> (SB + 1);
    return ROW_IW'(sh) & ROW_IW'(NR_ROWS - 1);
  endfunction

  function automatic logic [SLOT_IW-1:0] slot_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] sh;
    sh = pc >> 1;
    return SLOT_IW'(sh) & SLOT_IW'(FETCH_SLOTS - 1);
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] sh;
    sh = pc >> (1 + SB + ROW_W);
    return TAG_BITS'(sh);
  endfunction

  logic                valid_q  [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic                valid_d  [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic [TAG_BITS-1:0] tag_q    [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic [TAG_BITS-1:0] tag_d    [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic [VLEN-1:0]     target_q [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic [VLEN-1:0]     target_d [NR_ROWS][FETCH_SLOTS][NR_WAYS];
  logic [PTR_W-1:0]    ptr_q    [NR_ROWS][FETCH_SLOTS];
  logic [PTR_W-1:0]    ptr_d    [NR_ROWS][FETCH_SLOTS];
  logic [ROW_IW-1:0]   cnt_q, cnt_d;
  logic [0:0]          state_q, state_d;

  logic [ROW_IW-1:0]   lk_row, up_row;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic [SLOT_IW-1:0]  up_slot;
  logic                hit_any, inv_any;
  logic [PTR_W-1:0]    hit_way, inv_way, vic_way;

  // Lookup: at most one way can match, so the last match wins harmlessly.
  always_comb begin
    lk_row            = row_of(bus.vpc_i);
    lk_tag            = tag_of(bus.vpc_i);
    bus.pred_valid_o  = '0;
    bus.pred_target_o = '0;
    for (int unsigned s = 0; s < FETCH_SLOTS; s++) begin
      for (int unsigned w = 0; w < NR_WAYS; w++) begin
        if (state_q == IDLE && valid_q[lk_row][SLOT_IW'(s)][PTR_W'(w)] &&
            tag_q[lk_row][SLOT_IW'(s)][PTR_W'(w)] == lk_tag) begin
          bus.pred_valid_o[s]              = 1'b1;
          bus.pred_target_o[s*VLEN +: VLEN] = target_q[lk_row][SLOT_IW'(s)][PTR_W'(w)];
        end
      end
    end
  end

  assign bus.flush_busy_o = (state_q == FLUSH);

  always_comb begin
    up_row  = row_of(bus.update_pc_i);
    up_slot = slot_of(bus.update_pc_i);
    up_tag  = tag_of(bus.update_pc_i);
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      if (valid_q[up_row][up_slot][PTR_W'(w)] &&
          tag_q[up_row][up_slot][PTR_W'(w)] == up_tag) begin
        hit_any = 1'b1;
        hit_way = PTR_W'(w);
      end
      if (!valid_q[up_row][up_slot][PTR_W'(w)] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
    vic_way = hit_any ? hit_way : (inv_any ? inv_way : ptr_q[up_row][up_slot]);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (!bus.debug_mode_i) begin
          if (bus.update_clear_i) begin
            if (hit_any) valid_d[up_row][up_slot][hit_way] = 1'b0;
          end else if (bus.update_valid_i) begin
            valid_d[up_row][up_slot][vic_way]  = 1'b1;
            tag_d[up_row][up_slot][vic_way]    = up_tag;
            target_d[up_row][up_slot][vic_way] = bus.update_target_i;
            if (NR_WAYS > 1 && !hit_any && !inv_any)
              ptr_d[up_row][up_slot] = ptr_q[up_row][up_slot] + 1'b1;
          end
        end
      end
      default: begin
        for (int unsigned s = 0; s < FETCH_SLOTS; s++) begin
          ptr_d[cnt_q][SLOT_IW'(s)] = '0;
          for (int unsigned w = 0; w < NR_WAYS; w++)
            valid_d[cnt_q][SLOT_IW'(s)][PTR_W'(w)] = 1'b0;
        end
        if (cnt_q == ROW_IW'(NR_ROWS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '{default: '0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ptr_q    <= '{default: '0};
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the frontend. Successor to the direct-mapped BTB.
- Adds partial tags against aliasing, configurable associativity with fill-invalid-first/round-robin replacement, explicit entry invalidation, and a multi-cycle row-sequenced flush with a busy indication.
- Sits beside the BHT in the IF stage. Provides one target prediction per fetch slot. Updated from the execute stage on mispredicts.

Parameters:
- NR_ENTRIES, 32, total entries. Must equal a power of two ≥ NR_WAYS*FETCH_SLOTS.
- NR_WAYS, 2, associativity per (row, slot). Power of two, ≥1.
- FETCH_SLOTS, 2, compressed-instruction slots per fetch. Power of two.
- TAG_BITS, 8, partial PC tag width stored per entry.
- VLEN, 64, virtual address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  start full BTB invalidation
- debug_mode_i  in  1  when high, blocks all updates and clears
- vpc_i  in  VLEN  fetch virtual PC
- update_valid_i  in  1  write target for update_pc_i
- update_clear_i  in  1  invalidate entry matching update_pc_i
- update_pc_i  in  VLEN  PC of the resolved branch
- update_target_i  in  VLEN  resolved target
- pred_valid_o  out  FETCH_SLOTS  per-slot hit
- pred_target_o  out  FETCH_SLOTS*VLEN  per-slot target; slot s occupies bits [s*VLEN +: VLEN]
- flush_busy_o  out  1  flush sequence in progress

Behaviour:
- Geometry:
  - NR_ROWS = NR_ENTRIES/(NR_WAYS*FETCH_SLOTS).
  - PC[0] ignored.
  - Slot = PC[SB:1], with SB = log2(FETCH_SLOTS).
  - Row = next log2(NR_ROWS) bits.
  - Tag = next TAG_BITS bits.
  - Defaults: slot = pc[1], row = pc[4:2], tag = pc[12:5].
- Storage per (row, slot, way): valid, tag, target. Storage per (row, slot): one log2(NR_WAYS)-bit round-robin pointer (absent when NR_WAYS=1).
- Lookup (combinational from flops, 0-cycle latency):
  - For slot s, pred_valid_o[s] = 1 iff some way at [row(vpc_i)][s] is valid with a matching tag.
  - pred_target_o[s] = that way's target. It is 0 on a miss.
  - Each slot uses the row of vpc_i and compares tag(vpc_i).
  - At most one way hits; the update rules guarantee this.
- Update (update_valid_i && !debug_mode_i && FSM==IDLE), written at the clock edge and visible the next cycle:
  - Tag hit in the target row/slot: overwrite that way's target. Pointer unchanged.
  - Otherwise, if an invalid way exists: write the lowest-indexed invalid way, set valid. Pointer unchanged.
  - Otherwise: write the way at the pointer, then pointer = (pointer+1) mod NR_WAYS.
- Clear (update_clear_i && !debug_mode_i && FSM==IDLE):
  - Tag-hit way valid <= 0. No effect on a miss.
  - If clear and valid are asserted together, clear wins; nothing is written.
- Same-cycle lookup of the entry being updated returns the old contents.
- FSM:
  - States: IDLE, FLUSH.
  - IDLE, flush_i=1 → FLUSH. Row counter = 0. The update/clear in that cycle is dropped.
  - FLUSH, each cycle: clear valid of all ways/slots of row[counter] and reset its pointers; counter++.
  - FLUSH, counter==NR_ROWS-1 → IDLE after clearing that row.
  - flush_i while in FLUSH is ignored; the sequence continues.
  - flush_busy_o = (state==FLUSH), registered.
  - pred_valid_o is forced to 0 while in FLUSH.
  - Updates and clears are dropped while in FLUSH.
  - Flush duration is exactly NR_ROWS cycles (8 at defaults). First lookup hit is possible in the cycle after flush_busy_o falls.
- Reset (any time, including mid-flush):
  - All valid bits, tags, targets, pointers and the counter go to 0. State = IDLE.
  - Outputs: pred_valid_o=0, pred_target_o=0, flush_busy_o=0.
- Width rules:
  - Counter is max(1, log2(NR_ROWS)) bits.
  - Targets are stored full VLEN, not compressed.

Test Plan:
- Reset, vpc_i=0x1000 → pred_valid_o=2'b00, pred_target_o=0, flush_busy_o=0.
- Hit/alias:
  - Update pc=0x80000010, target=0x80000100.
  - Next cycle vpc_i=0x80000010 → pred_valid_o[0]=1, target 0x80000100.
  - vpc_i=0x80000030 (same row, tag differs) → pred_valid_o=00.
- Replacement:
  - Updates pc 0x10→T1, 0x30→T2: both hit.
  - Then 0x50→T3 evicts way0 (pointer 0→1): 0x10 misses, 0x30/0x50 hit.
  - Then 0x70→T4 evicts way1 (0x30).
- Flush:
  - Populate rows 0..7, pulse flush_i 1 cycle → flush_busy_o high exactly 8 cycles, pred_valid_o=0 throughout.
  - Update issued mid-flush is dropped; all lookups miss afterwards.
  - Assert rst_ni low mid-flush → flush_busy_o=0 immediately.
- debug_mode_i=1 with update_valid_i for pc 0x90 → next-cycle lookup of 0x90 misses.
- Clear:
  - With 0x30 and 0x50 resident, update_clear_i for pc 0x30 → 0x30 misses next cycle, 0x50 still hits.
  - Next update to 0x70 fills the freed way without moving the pointer.
